// File: rtl/spi_burst_pkg.sv
// spi_burst_pkg: shared FSM state encoding and default FIFO depth
// for the SPI burst sequencer and its FIFOs.
package spi_burst_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        XFER  = 2'd2,
        STORE = 2'd3
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: 8-bit first-word fall-through FIFO, DEPTH entries.
// Ports: clk_i/rst_ni (sync, active-low), push_i/data_i in, pop_i,
//        data_o (head, 0 when empty), full_o, empty_o, count_o.
module sync_fifo
    import spi_burst_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    input  logic        pop_i,
    output logic [7:0]  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == DEPTH_L);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];

    // Overflowing pushes and underflowing pops are silently dropped.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/spi_burst.sv
// spi_burst: multi-byte burst sequencer in front of the SPI byte engine.
// Ports: host TX/RX FIFO handshakes, start/len/busy/done/err control,
//        spi_* handshake to the byte engine. Sync active-low rst.
module spi_burst
    import spi_burst_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        start,
    input  logic [AW:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  spi_data_in,
    output logic        spi_ready_send,
    input  logic [7:0]  spi_data_out,
    input  logic        spi_busy
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_e      state_q;
    logic [AW:0] remaining_q;
    logic [AW:0] remaining_d;
    logic [7:0]  data_in_q;
    logic        send_q;
    logic        done_q;
    logic        err_q;

    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic [AW:0] tx_count;
    logic        rx_full;
    logic        rx_empty;
    logic [AW:0] rx_count;

    logic        accept;
    logic        store_ok;
    logic        tx_pop;
    logic        rx_push;
    logic        unused_ok;

    assign unused_ok = ^{rx_count, tx_empty};

    assign accept = (state_q == IDLE) && start && (len != '0)
                  && (len <= DEPTH_L) && (tx_count >= len);

    // The stall decision uses the registered full flag, so a same-cycle
    // host pop on a full RX FIFO still costs one extra STORE cycle.
    assign store_ok    = (state_q == STORE) && !rx_full;
    assign rx_push     = store_ok;
    assign tx_pop      = accept || (store_ok && (remaining_q != ONE));
    assign remaining_d = remaining_q - ONE;

    assign tx_ready       = !tx_full;
    assign rx_valid       = !rx_empty;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign spi_data_in    = data_in_q;
    assign spi_ready_send = send_q;

    sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (tx_valid && tx_ready),
        .data_i  (tx_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (rx_push),
        .data_i  (spi_data_out),
        .pop_i   (rx_valid && rx_ready),
        .data_o  (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_in_q   <= 8'h00;
            send_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_in_q   <= tx_head;
                        send_q      <= 1'b1;
                        remaining_q <= len;
                        state_q     <= REQ;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (spi_busy) begin
                        send_q  <= 1'b0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (!spi_busy) state_q <= STORE;
                end
                STORE: begin
                    if (!rx_full) begin
                        remaining_q <= remaining_d;
                        if (remaining_q == ONE) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            data_in_q <= tx_head;
                            send_q    <= 1'b1;
                            state_q   <= REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst.sv
// tb_spi_burst: directed self-checking bench for spi_burst with a
// loopback byte-engine model that echoes each transmitted byte.
module tb_spi_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = 5'd0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] spi_data_in;
    logic       spi_ready_send;
    logic [7:0] spi_data_out;
    logic       spi_busy;

    int vec = 0;
    int miss = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int stab_err = 0;
    logic [7:0] sent_q[$];

    spi_burst dut (
        .clk            (clk),
        .rst            (rst),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .start          (start),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .spi_data_in    (spi_data_in),
        .spi_ready_send (spi_ready_send),
        .spi_data_out   (spi_data_out),
        .spi_busy       (spi_busy)
    );

    always #5 clk = ~clk;

    // Loopback byte engine: 3-cycle busy window, echoes spi_data_in.
    initial begin
        int cnt;
        logic [7:0] lat;
        cnt = 0;
        lat = 8'h00;
        spi_busy = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                spi_busy = 1'b0;
                cnt = 0;
            end else if (spi_busy) begin
                if (spi_data_in !== lat) stab_err++;
                if (cnt == 0) spi_busy = 1'b0;
                else cnt--;
            end else if (spi_ready_send) begin
                lat = spi_data_in;
                spi_data_out = spi_data_in;
                sent_q.push_back(spi_data_in);
                spi_busy = 1'b1;
                cnt = 2;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (spi_ready_send && !prev) rise_cnt++;
            prev = spi_ready_send;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] l);
        start = 1'b1;
        len = l;
        step(1);
        start = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
        if (done !== 1'b1) begin
            vec++; miss++;
            $display("FAIL wait_done: done=%b required 1 within %0d cycles",
                     done, lim);
        end
    endtask

    task automatic test_reset();
        step(2);
        vec++; if (tx_ready !== 1'b1) begin miss++;
            $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        vec++; if (rx_valid !== 1'b0) begin miss++;
            $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        vec++; if (rx_data !== 8'h00) begin miss++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        vec++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miss++;
            $display("FAIL reset_ctl: busy/done/err=%b%b%b want 000",
                     busy, done, err); end
        vec++; if (spi_data_in !== 8'h00 || spi_ready_send !== 1'b0) begin miss++;
            $display("FAIL reset_spi: data_in=%h send=%b want 00/0",
                     spi_data_in, spi_ready_send); end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        sent_q.delete();
        push_byte(8'hA5);
        push_byte(8'h3C);
        pulse_start(5'd2);
        vec++; if (busy !== 1'b1 || spi_ready_send !== 1'b1) begin miss++;
            $display("FAIL basic_start: busy=%b send=%b want 1/1",
                     busy, spi_ready_send); end
        vec++; if (spi_data_in !== 8'hA5) begin miss++;
            $display("FAIL basic_head: got %h want a5", spi_data_in); end
        wait_done(200);
        vec++; if (busy !== 1'b0) begin miss++;
            $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        step(1);
        vec++; if (done !== 1'b0) begin miss++;
            $display("FAIL basic_done_pulse: got %b want 0", done); end
        vec++; if (done_cnt - d0 != 1) begin miss++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        vec++; if (sent_q.size() != 2 || sent_q[0] !== 8'hA5
                   || sent_q[1] !== 8'h3C) begin miss++;
            $display("FAIL basic_sent: size %0d want 2 bytes a5,3c",
                     sent_q.size()); end
        vec++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin miss++;
            $display("FAIL basic_rx0: valid=%b data=%h want 1/a5",
                     rx_valid, rx_data); end
        pop_rx();
        vec++; if (rx_data !== 8'h3C) begin miss++;
            $display("FAIL basic_rx1: got %h want 3c", rx_data); end
        pop_rx();
        vec++; if (rx_valid !== 1'b0) begin miss++;
            $display("FAIL basic_rx_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_err();
        int r0;
        r0 = rise_cnt;
        push_byte(8'hC1);
        push_byte(8'hC2);
        pulse_start(5'd3);
        vec++; if (err !== 1'b1 || busy !== 1'b0) begin miss++;
            $display("FAIL err_short: err=%b busy=%b want 1/0", err, busy); end
        step(1);
        vec++; if (err !== 1'b0) begin miss++;
            $display("FAIL err_pulse: got %b want 0", err); end
        pulse_start(5'd0);
        vec++; if (err !== 1'b1 || busy !== 1'b0) begin miss++;
            $display("FAIL err_len0: err=%b busy=%b want 1/0", err, busy); end
        step(5);
        vec++; if (rise_cnt != r0 || spi_ready_send !== 1'b0) begin miss++;
            $display("FAIL err_no_send: rises=%0d send=%b want 0/0",
                     rise_cnt - r0, spi_ready_send); end
        apply_reset();
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        vec++; if (tx_ready !== 1'b0) begin miss++;
            $display("FAIL txfull_ready: got %b want 0", tx_ready); end
        push_byte(8'hFF);
        pulse_start(5'd16);
        vec++; if (busy !== 1'b1 || spi_data_in !== 8'h40) begin miss++;
            $display("FAIL txfull_start16: busy=%b data_in=%h want 1/40",
                     busy, spi_data_in); end
        wait_done(400);
        vec++; if (tx_ready !== 1'b1) begin miss++;
            $display("FAIL txfull_drained: got %b want 1", tx_ready); end
        step(1);
        pulse_start(5'd1);
        vec++; if (err !== 1'b1) begin miss++;
            $display("FAIL txfull_dropped: err=%b want 1 (tx empty)", err); end
    endtask

    task automatic test_rx_stall();
        push_byte(8'h99);
        pulse_start(5'd1);
        step(20);
        vec++; if (busy !== 1'b1 || done !== 1'b0
                   || spi_ready_send !== 1'b0) begin miss++;
            $display("FAIL stall_hold: busy/done/send=%b%b%b want 100",
                     busy, done, spi_ready_send); end
        vec++; if (rx_data !== 8'h40) begin miss++;
            $display("FAIL stall_head: got %h want 40", rx_data); end
        pop_rx();
        vec++; if (done !== 1'b0 || busy !== 1'b1) begin miss++;
            $display("FAIL stall_after_pop: done=%b busy=%b want 0/1",
                     done, busy); end
        step(1);
        vec++; if (done !== 1'b1 || busy !== 1'b0) begin miss++;
            $display("FAIL stall_release: done=%b busy=%b want 1/0",
                     done, busy); end
        for (int i = 1; i < 16; i++) begin
            vec++; if (rx_data !== 8'h40 + 8'(i)) begin miss++;
                $display("FAIL stall_order%0d: got %h want %h",
                         i, rx_data, 8'h40 + 8'(i)); end
            pop_rx();
        end
        vec++; if (rx_data !== 8'h99) begin miss++;
            $display("FAIL stall_last: got %h want 99", rx_data); end
        pop_rx();
        vec++; if (rx_valid !== 1'b0) begin miss++;
            $display("FAIL stall_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        int d0;
        int r0;
        for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
        pulse_start(5'd4);
        n = 0;
        while (!(busy && spi_busy && !spi_ready_send) && n < 50) begin
            step(1);
            n++;
        end
        if (!(busy && spi_busy && !spi_ready_send)) begin
            vec++; miss++;
            $display("FAIL rstmid_xfer: busy=%b spi_busy=%b send=%b",
                     busy, spi_busy, spi_ready_send);
        end
        apply_reset();
        d0 = done_cnt;
        r0 = rise_cnt;
        vec++; if (busy !== 1'b0 || spi_ready_send !== 1'b0
                   || done !== 1'b0) begin miss++;
            $display("FAIL rstmid_ctl: busy/send/done=%b%b%b want 000",
                     busy, spi_ready_send, done); end
        vec++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0
                   || spi_data_in !== 8'h00) begin miss++;
            $display("FAIL rstmid_fifo: txr=%b rxv=%b din=%h want 1/0/00",
                     tx_ready, rx_valid, spi_data_in); end
        step(10);
        vec++; if (done_cnt != d0 || rise_cnt != r0) begin miss++;
            $display("FAIL rstmid_quiet: dones=%0d rises=%0d want 0/0",
                     done_cnt - d0, rise_cnt - r0); end
        pulse_start(5'd1);
        vec++; if (err !== 1'b1) begin miss++;
            $display("FAIL rstmid_flushed: err=%b want 1", err); end
    endtask

    task automatic test_back_to_back();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        pulse_start(5'd2);
        step(2);
        pulse_start(5'd1);
        vec++; if (err !== 1'b0 || busy !== 1'b1) begin miss++;
            $display("FAIL b2b_ignored: err=%b busy=%b want 0/1", err, busy); end
        wait_done(200);
        start = 1'b1;
        len = 5'd1;
        step(1);
        start = 1'b0;
        vec++; if (busy !== 1'b1 || spi_data_in !== 8'h33
                   || err !== 1'b0) begin miss++;
            $display("FAIL b2b_restart: busy=%b din=%h err=%b want 1/33/0",
                     busy, spi_data_in, err); end
        wait_done(200);
        step(1);
        vec++; if (rx_data !== 8'h11) begin miss++;
            $display("FAIL b2b_rx0: got %h want 11", rx_data); end
        pop_rx();
        vec++; if (rx_data !== 8'h22) begin miss++;
            $display("FAIL b2b_rx1: got %h want 22", rx_data); end
        pop_rx();
        vec++; if (rx_data !== 8'h33) begin miss++;
            $display("FAIL b2b_rx2: got %h want 33", rx_data); end
        pop_rx();
        vec++; if (rx_valid !== 1'b0) begin miss++;
            $display("FAIL b2b_empty: got %b want 0", rx_valid); end
        vec++; if (stab_err != 0) begin miss++;
            $display("FAIL data_in_stable: %0d changes want 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_tx_full();
        test_rx_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
